// File: rtl/channel_in_acc_ctrl_pkg.sv
// channel_in_acc_ctrl_pkg: lane geometry, FSM states and beat tag shared by the accumulator controller
package channel_in_acc_ctrl_pkg;
  localparam int PICTURE_NUM = 4;
  localparam int WIDTH_DATA_OUT = 8;
  localparam int DEF_LANES = PICTURE_NUM;
  localparam int DEF_LANE_W = 2 * WIDTH_DATA_OUT;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
endpackage

// File: rtl/channel_in_acc_ctrl_acc_tag_delay.sv
// acc_tag_delay: fixed-depth shift register of beat tags matching the reduction tree latency
module acc_tag_delay
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout,
  output logic any_valid
);
  tag_t [DEPTH-1:0] sr;
  assign dout = sr[DEPTH-1];
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end
  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_valid = any_valid | sr[k].valid;
  end
endmodule

// File: rtl/channel_in_acc_ctrl.sv
// channel_in_acc_ctrl: sequences 4-channel groups per pixel and accumulates tree outputs lane-wise
module channel_in_acc_ctrl
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int TREE_LAT = 4,
  parameter int GRP_W = 8,
  parameter int PIX_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [GRP_W-1:0]          cfg_groups,
  input  logic [PIX_W-1:0]          cfg_pixels,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   tree_data,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done
);
  localparam int DW = LANES * LANE_W;
  state_t state, state_nx;
  logic [GRP_W-1:0] groups, grp_cnt;
  logic [PIX_W-1:0] pixels, pix_cnt;
  logic [DW-1:0] acc, acc_sum;
  logic accept, last, final_beat, any_valid;
  tag_t tag_in, tag_out;
  assign in_ready = state == ST_RUN;
  assign busy = state != ST_IDLE;
  assign accept = in_valid && in_ready;
  assign last = grp_cnt == groups - 1'b1;
  assign final_beat = accept && last && pix_cnt == pixels - 1'b1;
  assign tag_in = '{valid: accept, first: grp_cnt == '0, last: last};
  assign out_data = acc;
  always_comb begin
    state_nx = state;
    state_nx = state == ST_IDLE ? (start && cfg_pixels != '0 ? ST_RUN : ST_IDLE)
             : state == ST_RUN  ? (final_beat ? ST_DRAIN : ST_RUN)
             : (any_valid ? ST_DRAIN : ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      groups <= '0;
      pixels <= '0;
      grp_cnt <= '0;
      pix_cnt <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= tag_out.valid && tag_out.last;
      done <= (state == ST_DRAIN && !any_valid) || (state == ST_IDLE && start && cfg_pixels == '0);
      if (state == ST_IDLE && start) begin
        groups <= cfg_groups == '0 ? GRP_W'(1) : cfg_groups;
        pixels <= cfg_pixels;
        grp_cnt <= '0;
        pix_cnt <= '0;
      end else if (accept) begin
        grp_cnt <= last ? '0 : grp_cnt + 1'b1;
        pix_cnt <= last ? pix_cnt + 1'b1 : pix_cnt;
      end
    end
  end
  // lanes wrap independently; no carry crosses a lane boundary
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign acc_sum[i*LANE_W +: LANE_W] = acc[i*LANE_W +: LANE_W] + tree_data[i*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (tag_out.valid) acc <= tag_out.first ? tree_data : acc_sum;
  end
  acc_tag_delay #(.DEPTH(TREE_LAT)) u_delay (
    .clk(clk),
    .rst(rst),
    .din(tag_in),
    .dout(tag_out),
    .any_valid(any_valid)
  );
endmodule

// File: tb/tb_channel_in_acc_ctrl.sv
// tb_channel_in_acc_ctrl: directed and random runs checked cycle by cycle against a pixel-sum model
module tb_channel_in_acc_ctrl;
  import channel_in_acc_ctrl_pkg::*;
  localparam int LN = DEF_LANES, LW = DEF_LANE_W, DW = LN * LW, TL = 4;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] cfg_groups = '0;
  logic [15:0] cfg_pixels = '0;
  logic [DW-1:0] tree_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [DW-1:0] out_data;
  int cyc = 0, n_tests = 0, n_fail = 0, done_n = 0, last_ov_cyc = -1;
  bit armed = 0;
  typedef struct {int due; bit f; bit l;} beat_t;
  typedef struct {int at; logic [DW-1:0] d;} res_t;
  beat_t pend_q[$];
  res_t exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] data_at[int];
  bit m_busy = 0, m_run = 0;
  int grp_size = 1, grp_pos = 0, beats_left = 0, done_at = -1, idle_at = -1;
  logic [DW-1:0] msum = '0;

  channel_in_acc_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_groups(cfg_groups), .cfg_pixels(cfg_pixels),
    .in_valid(in_valid), .in_ready(in_ready), .tree_data(tree_data), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] w;
    for (int i = 0; i < LN; i++) w[i*LW +: LW] = LW'($urandom);
    return w;
  endfunction
  function automatic logic [DW-1:0] rep(int v);
    logic [DW-1:0] w;
    for (int i = 0; i < LN; i++) w[i*LW +: LW] = LW'(v);
    return w;
  endfunction
  function void chkb(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
    end
  endfunction
  function void chkw(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction
  function void chki(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // tree output for a beat shows up TL cycles after it was accepted; random filler otherwise
  always @(posedge clk) begin
    #1;
    tree_data = data_at.exists(cyc) ? data_at[cyc] : rnd();
  end

  // model: each pixel's result is the lane-wise sum of its beats' tree words, due TL+1 after its last beat
  always @(negedge clk) begin
    bit ev;
    if (armed) begin
      ev = exp_q.size() > 0 && exp_q[0].at == cyc;
      chkb("in_ready", in_ready, m_run);
      chkb("busy", busy, m_busy);
      chkb("done", done, done_at == cyc);
      chkb("out_valid", out_valid, ev);
      if (ev) begin
        chkw("out_data", out_data, exp_q[0].d);
        void'(exp_q.pop_front());
      end
      if (out_valid) begin
        got_q.push_back(out_data);
        last_ov_cyc = cyc;
      end
      if (done) done_n++;
    end
    if (rst) begin
      armed = 1;
      m_busy = 0;
      m_run = 0;
      pend_q.delete();
      exp_q.delete();
      done_at = -1;
      idle_at = -1;
      msum = '0;
    end else begin
      while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        if (pend_q[0].f) msum = '0;
        for (int i = 0; i < LN; i++) msum[i*LW +: LW] = msum[i*LW +: LW] + tree_data[i*LW +: LW];
        if (pend_q[0].l) exp_q.push_back('{cyc + 1, msum});
        void'(pend_q.pop_front());
      end
      if (!m_busy && start) begin
        if (cfg_pixels == 0) done_at = cyc + 1;
        else begin
          m_busy = 1;
          m_run = 1;
          grp_size = cfg_groups == 0 ? 1 : int'(cfg_groups);
          beats_left = grp_size * int'(cfg_pixels);
          grp_pos = 0;
        end
      end else if (m_run && in_valid) begin
        pend_q.push_back('{cyc + TL, grp_pos == 0, grp_pos == grp_size - 1});
        grp_pos = (grp_pos + 1) % grp_size;
        beats_left--;
        if (beats_left == 0) begin
          m_run = 0;
          idle_at = cyc + TL + 2;
          done_at = cyc + TL + 2;
        end
      end
      if (m_busy && !m_run && idle_at == cyc + 1) m_busy = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 0;
    in_valid = 0;
    rst = 0;
  endtask
  task automatic go(int g, int p);
    cfg_groups = 8'(g);
    cfg_pixels = 16'(p);
    start = 1;
    step();
  endtask
  task automatic beat(logic [DW-1:0] d);
    in_valid = 1;
    data_at[cyc + TL] = d;
    step();
  endtask
  task automatic settle();
    for (int i = 0; i < 400; i++) begin
      if (!(m_busy || exp_q.size() != 0 || done_at >= cyc)) begin
        step();
        return;
      end
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL settle: timed out waiting for run end at cycle %0d", cyc);
  endtask

  initial begin
    int dn, t_last;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chkw("rst_out_data", out_data, '0);
    chkb("rst_out_valid", out_valid, 1'b0);
    // groups=1: one result per beat
    got_q.delete(); dn = done_n;
    go(1, 3);
    beat(rep(5)); beat(rep(6)); beat(rep(7));
    settle();
    chki("t1_count", got_q.size(), 3);
    if (got_q.size() == 3) for (int i = 0; i < 3; i++) chkw("t1_sum", got_q[i], rep(5 + i));
    chki("t1_done", done_n - dn, 1);
    // groups=3, two pixels back to back
    got_q.delete(); dn = done_n;
    go(3, 2);
    beat(rep(1)); beat(rep(2)); beat(rep(3)); beat(rep(10)); beat(rep(20)); beat(rep(30));
    settle();
    chki("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chkw("t2_pix0", got_q[0], rep(6));
      chkw("t2_pix1", got_q[1], rep(60));
    end
    chki("t2_done", done_n - dn, 1);
    // per-lane wrap with no carry into neighbours
    got_q.delete();
    go(2, 1);
    beat({16'h0022, 16'h0011, 16'hFFFF, 16'h7FFF});
    beat({16'h0000, 16'h0000, 16'h0001, 16'h0001});
    settle();
    chki("t3_count", got_q.size(), 1);
    if (got_q.size() == 1) chkw("t3_wrap", got_q[0], {16'h0022, 16'h0011, 16'h0000, 16'h8000});
    // bubbles between beats
    got_q.delete();
    go(4, 1);
    for (int v = 1; v <= 4; v++) begin
      t_last = cyc;
      beat(rep(v));
      step(); step();
    end
    settle();
    chki("t4_count", got_q.size(), 1);
    if (got_q.size() == 1) chkw("t4_sum", got_q[0], rep(10));
    chki("t4_latency", last_ov_cyc - t_last, TL + 1);
    // reset mid-run abandons everything, then a clean run
    got_q.delete(); dn = done_n;
    go(4, 2);
    beat(rep(1)); beat(rep(2));
    step(); step();
    rst = 1;
    step();
    repeat (10) step();
    chki("t5_no_out", got_q.size(), 0);
    chki("t5_no_done", done_n - dn, 0);
    go(2, 1);
    beat(rep(3)); beat(rep(4));
    settle();
    chki("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) chkw("t5_sum", got_q[0], rep(7));
    // start during RUN ignored; start with zero pixels pulses done only
    got_q.delete(); dn = done_n;
    go(1, 2);
    beat(rep(8));
    go(3, 5);
    beat(rep(9));
    settle();
    chki("t6_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chkw("t6_pix0", got_q[0], rep(8));
      chkw("t6_pix1", got_q[1], rep(9));
    end
    dn = done_n;
    go(1, 0);
    chkb("t6_zero_done", done, 1'b1);
    chkb("t6_zero_busy", busy, 1'b0);
    step();
    chki("t6_zero_done_n", done_n - dn, 1);
    // random runs
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        go($urandom_range(0, 5), 0);
        step();
      end
      go($urandom_range(0, 5), $urandom_range(1, 4));
      for (int i = 0; i < 500 && m_run; i++) begin
        in_valid = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 7) == 0) begin
          start = 1;
          cfg_groups = 8'($urandom_range(0, 7));
          cfg_pixels = 16'($urandom_range(0, 7));
        end
        step();
      end
      settle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
